dma_host_mem_responder: RTL
===========================

Name: dma_host_mem_responder

Overview:
Responder end of the DMA command/data interface: a behavioural host-memory model that accepts DMA read/write commands and serves them from an internal 512-bit-wide RAM. Read commands return data streams; write commands consume data streams and store them. Used in place of the PCIe DMA core for simulation and on-chip loopback of DMA traffic generators/checkers. Read and write channels are fully independent and may run concurrently.

Parameters:
DEPTH, 1024, RAM depth in 64-byte words (power of 2)
ADDR_W, 10, log2(DEPTH)
FIXED_RD_LAT, 2, minimum cycles from read-cmd accept to first read-data valid (>=2)

Ports:
pcie_clk  in  1  sole clock
pcie_rst  in  1  synchronous, active-high reset
s_axis_dma_read_cmd_valid/ready  in/out  1/1  read-command handshake
s_axis_dma_read_cmd_address  in  64  byte address
s_axis_dma_read_cmd_length  in  32  byte length
m_axis_dma_read_data_valid/ready  out/in  1/1  read-data handshake
m_axis_dma_read_data_data  out  512  read beat
m_axis_dma_read_data_keep  out  64  byte valid mask
m_axis_dma_read_data_last  out  1  final beat of command
s_axis_dma_write_cmd_valid/ready/address/length  in/out/in/in  1/1/64/32  write command
s_axis_dma_write_data_valid/ready  in/out  1/1  write-data handshake
s_axis_dma_write_data_data/keep/last  in  512/64/1  write beat
rd_cmd_cnt, wr_cmd_cnt  out  32  accepted-command counters
error_cnt  out  32  protocol-error counter (saturating)

Behaviour:
- Reset: all valid/ready outputs 0, counters 0, FSMs IDLE, skid buffer empty; RAM contents not cleared. Reset mid-transfer aborts it immediately; beats in flight are dropped.
- Word address = address[ADDR_W+5:6], modulo DEPTH (wraps to 0 past DEPTH-1); address[5:0] is ignored and counts as error (+1) when nonzero.
- Beats = ceil(length/64). Last-beat keep = lower (length mod 64) bytes set, or all 64 if length mod 64 = 0; other beats all-ones.
- length = 0: command accepted, no data, error_cnt +1, FSM returns to IDLE next cycle.
- Read FSM IDLE -> RD_WAIT -> RD_STREAM -> IDLE. read_cmd_ready = 1 only in IDLE. On accept, latch word address and beat count, rd_cmd_cnt +1. RD_WAIT lasts FIXED_RD_LAT-1 cycles, then RAM reads (1-cycle latency) fill a 2-entry skid buffer; the first valid appears exactly FIXED_RD_LAT cycles after accept. Output is 1 beat/cycle while ready is held high. valid never drops without a handshake. last is asserted with the final beat; IDLE is entered on the cycle after the last handshake.
- Write FSM IDLE -> WR_DATA -> IDLE. write_cmd_ready = 1 only in IDLE; on accept, wr_cmd_cnt +1. In WR_DATA, write_data_ready = 1; each handshake writes RAM bytes where keep=1 and advances the address (with wrap). After the counted final beat: IDLE. If last is missing on the final beat, error_cnt +1. If last arrives early, error_cnt +1 and the FSM terminates at IDLE.
- RAM read/write to the same word in the same cycle: read returns old data (read-first).
- error_cnt saturates at 32'hFFFF_FFFF. Simultaneous error events on both channels add 2.

Optional Feature:
DMA_RESP_LAT_INJECT_EN: adds input rd_extra_lat[15:0], sampled at read-cmd accept. RD_WAIT is extended by that many cycles, so the first valid appears at FIXED_RD_LAT+rd_extra_lat cycles. Without the macro, the port is absent and the latency is exactly FIXED_RD_LAT.

Test Plan:
1. Write cmd addr 0x0, len 256, beats data=i -> 4 beats accepted, wr_cmd_cnt=1. Read cmd same -> first valid 2 cycles after accept, data 0..3, last on beat 3, keep all-ones, error_cnt=0.
2. Read len 100 at addr 0x40 -> 2 beats, last-beat keep=64'h0000_000F_FFFF_FFFF.
3. Read len 4096 with ready toggled 1/0 every cycle -> 64 beats in order, no loss or duplication, valid stable under stall.
4. Write 2 beats at word DEPTH-1 -> second beat lands in word 0; read back confirms.
5. Write len 256 with last on beat 1 -> error_cnt=1, FSM IDLE, next write cmd accepted; read cmd len 0 -> error_cnt=2, no data beats.
6. pcie_rst asserted mid-read at beat 10 of 64 -> valid 0 next cycle, read_cmd_ready 1 after release, counters 0. With DMA_RESP_LAT_INJECT_EN and rd_extra_lat=5 -> first valid 7 cycles after accept.

Source files
------------

// File: rtl/dma_host_mem_responder.sv
// Behavioural host-memory responder for the DMA read/write command+data streams.
// Optional macro DMA_RESP_LAT_INJECT_EN adds rd_extra_lat to stretch read latency.
module dma_host_mem_responder #(
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned FIXED_RD_LAT = 2
) (
  input  logic          pcie_clk,
  input  logic          pcie_rst,
  input  logic          s_axis_dma_read_cmd_valid,
  output logic          s_axis_dma_read_cmd_ready,
  input  logic [63:0]   s_axis_dma_read_cmd_address,
  input  logic [31:0]   s_axis_dma_read_cmd_length,
  output logic          m_axis_dma_read_data_valid,
  input  logic          m_axis_dma_read_data_ready,
  output logic [511:0]  m_axis_dma_read_data_data,
  output logic [63:0]   m_axis_dma_read_data_keep,
  output logic          m_axis_dma_read_data_last,
  input  logic          s_axis_dma_write_cmd_valid,
  output logic          s_axis_dma_write_cmd_ready,
  input  logic [63:0]   s_axis_dma_write_cmd_address,
  input  logic [31:0]   s_axis_dma_write_cmd_length,
  input  logic          s_axis_dma_write_data_valid,
  output logic          s_axis_dma_write_data_ready,
  input  logic [511:0]  s_axis_dma_write_data_data,
  input  logic [63:0]   s_axis_dma_write_data_keep,
  input  logic          s_axis_dma_write_data_last,
`ifdef DMA_RESP_LAT_INJECT_EN
  input  logic [15:0]   rd_extra_lat,
`endif
  output logic [31:0]   rd_cmd_cnt,
  output logic [31:0]   wr_cmd_cnt,
  output logic [31:0]   error_cnt
);

  localparam logic [1:0] RD_IDLE   = 2'd0;
  localparam logic [1:0] RD_WAIT   = 2'd1;
  localparam logic [1:0] RD_STREAM = 2'd2;
  localparam logic       WR_IDLE   = 1'b0;
  localparam logic       WR_DATA   = 1'b1;

  function automatic logic [31:0] beats_of(input logic [31:0] len);
    logic [32:0] t;
    t = {1'b0, len} + 33'd63;
    return {5'b0, t[32:6]};
  endfunction

  logic [511:0] mem [DEPTH];
  logic [511:0] fifo_data [2];
  logic [63:0]  fifo_keep [2];
  logic         fifo_last [2];

  logic [1:0]        rd_state_q, rd_state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [31:0]       rd_left_q, rd_left_d;
  logic [5:0]        rd_rem_q, rd_rem_d;
  logic [31:0]       rd_wait_q, rd_wait_d;
  logic [31:0]       rd_cmd_cnt_q, rd_cmd_cnt_d;
  logic              fifo_wr_ptr_q, fifo_wr_ptr_d;
  logic              fifo_rd_ptr_q, fifo_rd_ptr_d;
  logic [1:0]        fifo_cnt_q, fifo_cnt_d;
  logic              wr_state_q, wr_state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_left_q, wr_left_d;
  logic [31:0]       wr_cmd_cnt_q, wr_cmd_cnt_d;
  logic [31:0]       error_cnt_q, error_cnt_d;

  logic        rd_cmd_hs, rd_issue, rd_pop, issue_last, wr_cmd_hs, wr_hs;
  logic [63:0] issue_keep;
  logic [31:0] rd_lat_load;
  logic [1:0]  rd_err, wr_err;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{s_axis_dma_read_cmd_address[63:ADDR_W+6],
                              s_axis_dma_write_cmd_address[63:ADDR_W+6]};

`ifdef DMA_RESP_LAT_INJECT_EN
  assign rd_lat_load = 32'(FIXED_RD_LAT - 1) + {16'b0, rd_extra_lat};
`else
  assign rd_lat_load = 32'(FIXED_RD_LAT - 1);
`endif

  assign s_axis_dma_read_cmd_ready   = (rd_state_q == RD_IDLE) && !pcie_rst;
  assign s_axis_dma_write_cmd_ready  = (wr_state_q == WR_IDLE) && !pcie_rst;
  assign s_axis_dma_write_data_ready = (wr_state_q == WR_DATA) && !pcie_rst;
  assign m_axis_dma_read_data_valid  = (fifo_cnt_q != 2'd0) && !pcie_rst;
  assign m_axis_dma_read_data_data   = fifo_data[fifo_rd_ptr_q];
  assign m_axis_dma_read_data_keep   = fifo_keep[fifo_rd_ptr_q];
  assign m_axis_dma_read_data_last   = fifo_last[fifo_rd_ptr_q];

  assign rd_cmd_hs  = s_axis_dma_read_cmd_valid && s_axis_dma_read_cmd_ready;
  assign wr_cmd_hs  = s_axis_dma_write_cmd_valid && s_axis_dma_write_cmd_ready;
  assign wr_hs      = s_axis_dma_write_data_valid && s_axis_dma_write_data_ready;
  assign rd_pop     = m_axis_dma_read_data_valid && m_axis_dma_read_data_ready;
  // RAM read lands straight in the skid buffer, so space is the only issue condition
  assign rd_issue   = (rd_state_q == RD_STREAM) && (rd_left_q != 32'd0) && (fifo_cnt_q < 2'd2);
  assign issue_last = (rd_left_q == 32'd1);
  assign issue_keep = (issue_last && rd_rem_q != 6'd0) ? ~({64{1'b1}} << rd_rem_q) : '1;

  always_comb begin
    rd_state_d    = rd_state_q;
    rd_addr_d     = rd_addr_q;
    rd_left_d     = rd_left_q;
    rd_rem_d      = rd_rem_q;
    rd_wait_d     = rd_wait_q;
    rd_cmd_cnt_d  = rd_cmd_cnt_q;
    rd_err        = '0;
    fifo_wr_ptr_d = fifo_wr_ptr_q ^ rd_issue;
    fifo_rd_ptr_d = fifo_rd_ptr_q ^ rd_pop;
    fifo_cnt_d    = fifo_cnt_q + {1'b0, rd_issue} - {1'b0, rd_pop};
    case (rd_state_q)
      RD_IDLE: if (rd_cmd_hs) begin
        rd_cmd_cnt_d = rd_cmd_cnt_q + 32'd1;
        rd_addr_d    = s_axis_dma_read_cmd_address[ADDR_W+5:6];
        rd_left_d    = beats_of(s_axis_dma_read_cmd_length);
        rd_rem_d     = s_axis_dma_read_cmd_length[5:0];
        rd_wait_d    = rd_lat_load;
        rd_err       = {1'b0, s_axis_dma_read_cmd_address[5:0] != 6'd0}
                     + {1'b0, s_axis_dma_read_cmd_length == 32'd0};
        if (s_axis_dma_read_cmd_length != 32'd0) rd_state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (rd_wait_q <= 32'd1) rd_state_d = RD_STREAM;
        else rd_wait_d = rd_wait_q - 32'd1;
      end
      RD_STREAM: begin
        if (rd_issue) begin
          rd_addr_d = rd_addr_q + 1'b1;
          rd_left_d = rd_left_q - 32'd1;
        end
        if (rd_pop && m_axis_dma_read_data_last) rd_state_d = RD_IDLE;
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d   = wr_state_q;
    wr_addr_d    = wr_addr_q;
    wr_left_d    = wr_left_q;
    wr_cmd_cnt_d = wr_cmd_cnt_q;
    wr_err       = '0;
    case (wr_state_q)
      WR_IDLE: if (wr_cmd_hs) begin
        wr_cmd_cnt_d = wr_cmd_cnt_q + 32'd1;
        wr_addr_d    = s_axis_dma_write_cmd_address[ADDR_W+5:6];
        wr_left_d    = beats_of(s_axis_dma_write_cmd_length);
        wr_err       = {1'b0, s_axis_dma_write_cmd_address[5:0] != 6'd0}
                     + {1'b0, s_axis_dma_write_cmd_length == 32'd0};
        if (s_axis_dma_write_cmd_length != 32'd0) wr_state_d = WR_DATA;
      end
      default: if (wr_hs) begin
        wr_addr_d = wr_addr_q + 1'b1;
        wr_left_d = wr_left_q - 32'd1;
        // Both a missing and an early last end the command with one error
        if ((wr_left_q == 32'd1) != s_axis_dma_write_data_last) wr_err = 2'd1;
        if (wr_left_q == 32'd1 || s_axis_dma_write_data_last) wr_state_d = WR_IDLE;
      end
    endcase
  end

  always_comb begin
    logic [32:0] sum;
    sum = {1'b0, error_cnt_q} + 33'({1'b0, rd_err} + {1'b0, wr_err});
    error_cnt_d = sum[32] ? '1 : sum[31:0];
  end

  always_ff @(posedge pcie_clk) begin
    if (pcie_rst) begin
      rd_state_q    <= RD_IDLE;
      rd_addr_q     <= '0;
      rd_left_q     <= '0;
      rd_rem_q      <= '0;
      rd_wait_q     <= '0;
      rd_cmd_cnt_q  <= '0;
      fifo_wr_ptr_q <= 1'b0;
      fifo_rd_ptr_q <= 1'b0;
      fifo_cnt_q    <= '0;
      wr_state_q    <= WR_IDLE;
      wr_addr_q     <= '0;
      wr_left_q     <= '0;
      wr_cmd_cnt_q  <= '0;
      error_cnt_q   <= '0;
    end else begin
      rd_state_q    <= rd_state_d;
      rd_addr_q     <= rd_addr_d;
      rd_left_q     <= rd_left_d;
      rd_rem_q      <= rd_rem_d;
      rd_wait_q     <= rd_wait_d;
      rd_cmd_cnt_q  <= rd_cmd_cnt_d;
      fifo_wr_ptr_q <= fifo_wr_ptr_d;
      fifo_rd_ptr_q <= fifo_rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      wr_state_q    <= wr_state_d;
      wr_addr_q     <= wr_addr_d;
      wr_left_q     <= wr_left_d;
      wr_cmd_cnt_q  <= wr_cmd_cnt_d;
      error_cnt_q   <= error_cnt_d;
    end
  end

  // Storage is not reset; non-blocking read of mem gives read-first ordering
  always_ff @(posedge pcie_clk) begin
    if (wr_hs) begin
      for (int unsigned b = 0; b < 64; b++) begin
        if (s_axis_dma_write_data_keep[b])
          mem[wr_addr_q][8*b +: 8] <= s_axis_dma_write_data_data[8*b +: 8];
      end
    end
    if (rd_issue) begin
      fifo_data[fifo_wr_ptr_q] <= mem[rd_addr_q];
      fifo_keep[fifo_wr_ptr_q] <= issue_keep;
      fifo_last[fifo_wr_ptr_q] <= issue_last;
    end
  end

  assign rd_cmd_cnt = rd_cmd_cnt_q;
  assign wr_cmd_cnt = wr_cmd_cnt_q;
  assign error_cnt  = error_cnt_q;

endmodule
